mdu_iterative: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that sits in the execute stage beside the single-cycle ALU.
- Accepts one operation per start pulse. Raises stall_req so the PC register and the stage registers hold while it runs.
- Returns a 2*WIDTH result as lo/hi halves, matching the 32-bit stage-3 ALU result path for WIDTH=16.
- Adds signed/unsigned modes, the div0 and overflow flags, and a flush that the single-cycle ALU path lacks.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_iterative_if.sv | 29 ++
 rtl/mdu_twos_neg.sv | 10 +
 rtl/mdu_iterative.sv | 154 +++++++++++++++
 tb/tb_mdu_iterative.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared types and op decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'd0,
    MULU = 2'd1,
    DIV  = 2'd2,
    DIVU = 2'd3
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_e;

  function automatic logic is_signed(mdu_op_e op);
    return (op == MUL) || (op == DIV);
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mdu_iterative_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div0;
  logic             overflow;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall_req, done, result_lo, result_hi, div0, overflow
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall_req, done, result_lo, result_hi, div0, overflow
  );
endinterface

// File: rtl/mdu_twos_neg.sv
// Conditional two's-complement: passes din through, or negates it when neg is set.
module mdu_twos_neg #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);
  assign dout = neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;
endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle shift-add multiplier / restoring divider with signed modes,
// div0/overflow flags, flush and a stall request for the surrounding pipeline.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            rst,
  mdu_iterative_if.slave bus
);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e         state, state_nxt;
  mdu_op_e            op_r;
  logic [WIDTH-1:0]   a_r, b_r, ma, mb;
  logic [2*WIDTH-1:0] acc, acc_mul, acc_div, prod;
  logic [CNT_W-1:0]   cnt;
  logic               neg_lo, neg_hi, pend_div0, pend_ovf;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               div0_r, ovf_r;
  logic               idle_or_done, accept, div_zero, div_ovf, sgn;
  logic               busy_c, done_c;
  logic [WIDTH-1:0]   na_in, nb_in, na_out, nb_out;
  logic               na_en, nb_en;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic               mul_ovf;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign accept       = bus.start && !bus.flush && idle_or_done;
  assign sgn          = is_signed(op_r);
  assign div_zero     = is_div(op_r) && (b_r == '0);
  assign div_ovf      = (op_r == DIV) && (a_r == MIN_VAL) && (b_r == ALL_ONES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = PREP;
      PREP: begin
        busy_c    = 1'b1;
        state_nxt = (div_zero || div_ovf) ? FIX : RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX: begin
        busy_c    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = accept ? PREP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // The operand negators double as quotient/remainder fix-up once PREP is over.
  assign na_in = (state == PREP) ? a_r : acc[WIDTH-1:0];
  assign nb_in = (state == PREP) ? b_r : acc[2*WIDTH-1:WIDTH];
  assign na_en = (state == PREP) ? (sgn && a_r[WIDTH-1]) : neg_lo;
  assign nb_en = (state == PREP) ? (sgn && b_r[WIDTH-1]) : neg_hi;

  mdu_twos_neg #(.WIDTH(WIDTH))   u_neg_a (.din(na_in), .neg(na_en),  .dout(na_out));
  mdu_twos_neg #(.WIDTH(WIDTH))   u_neg_b (.din(nb_in), .neg(nb_en),  .dout(nb_out));
  mdu_twos_neg #(.WIDTH(2*WIDTH)) u_neg_p (.din(acc),   .neg(neg_lo), .dout(prod));

  // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? ma : {WIDTH{1'b0}})};
  assign acc_mul = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
  assign acc_div   = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign mul_ovf = (op_r == MUL) ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                 : (prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});

  always_ff @(posedge clk) begin
    if (accept) begin
      op_r <= bus.op;
      a_r  <= bus.a;
      b_r  <= bus.b;
    end
    if (state == PREP) begin
      ma        <= na_out;
      mb        <= nb_out;
      pend_div0 <= div_zero;
      pend_ovf  <= div_ovf;
      // Early exits preload acc so FIX publishes them through the normal divide path.
      if (div_zero) begin
        acc    <= {a_r, ALL_ONES};
        neg_lo <= 1'b0;
        neg_hi <= 1'b0;
      end else if (div_ovf) begin
        acc    <= {{WIDTH{1'b0}}, MIN_VAL};
        neg_lo <= 1'b0;
        neg_hi <= 1'b0;
      end else begin
        acc    <= is_div(op_r) ? {{WIDTH{1'b0}}, na_out} : {{WIDTH{1'b0}}, nb_out};
        neg_lo <= (sgn && a_r[WIDTH-1]) ^ (sgn && b_r[WIDTH-1]);
        neg_hi <= sgn && a_r[WIDTH-1];
      end
    end else if (state == RUN) begin
      acc <= is_div(op_r) ? acc_div : acc_mul;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      res_lo <= '0;
      res_hi <= '0;
      div0_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (state == PREP)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + CNT_W'(1);
      if ((state == FIX) && !bus.flush) begin
        if (is_div(op_r)) begin
          res_lo <= na_out;
          res_hi <= nb_out;
          div0_r <= pend_div0;
          ovf_r  <= pend_ovf;
        end else begin
          res_lo <= prod[WIDTH-1:0];
          res_hi <= prod[2*WIDTH-1:WIDTH];
          div0_r <= 1'b0;
          ovf_r  <= mul_ovf;
        end
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.stall_req = busy_c || (bus.start && idle_or_done);
  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;
  assign bus.div0      = div0_r;
  assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_mdu_iterative.sv
// Randomised and directed bench for mdu_iterative against an arithmetic reference model.
module tb_mdu_iterative;
  import mdu_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        div0;
    logic        ovf;
  } res_t;

  typedef struct {
    int   e0;
    int   lat;
    res_t r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_iterative_if #(.WIDTH(W)) bus();
  mdu_iterative #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t q[$];
  res_t held = '0;
  int   cyc = 0;
  int   flush_edge = -1;
  int   checks = 0;
  int   passed = 0;
  logic done_exp, busy_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic res_t mk(logic [15:0] lo, logic [15:0] hi, logic d0, logic ov);
    res_t r;
    r.lo = lo; r.hi = hi; r.div0 = d0; r.ovf = ov;
    return r;
  endfunction

  function automatic res_t model(mdu_op_e op, logic [15:0] a, logic [15:0] b);
    res_t   r;
    longint p;
    int     sa, sb;
    r  = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MUL: begin
        p = longint'(sa) * longint'(sb);
        r.lo = p[15:0]; r.hi = p[31:16];
        r.ovf = (p < -32768) || (p > 32767);
      end
      MULU: begin
        p = longint'(a) * longint'(b);
        r.lo = p[15:0]; r.hi = p[31:16];
        r.ovf = (p > 65535);
      end
      default: begin
        if (b == 16'h0) begin
          r.lo = 16'hFFFF; r.hi = a; r.div0 = 1'b1;
        end else if (op == DIV && a == 16'h8000 && b == 16'hFFFF) begin
          r.lo = 16'h8000; r.hi = 16'h0; r.ovf = 1'b1;
        end else if (op == DIV) begin
          r.lo = 16'(sa / sb); r.hi = 16'(sa % sb);
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  function automatic int model_lat(mdu_op_e op, logic [15:0] a, logic [15:0] b);
    if (is_div(op) && ((b == 16'h0) || (op == DIV && a == 16'h8000 && b == 16'hFFFF))) return 2;
    return W + 2;
  endfunction

  function automatic logic model_busy();
    foreach (q[i]) if (cyc >= q[i].e0 && cyc < q[i].e0 + q[i].lat) return 1'b1;
    return 1'b0;
  endfunction

  // Every cycle out of reset: done/busy/stall timing and the held result must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (cyc == flush_edge) while (q.size() > 0 && q[0].e0 < cyc) q.delete(0);
      done_exp = 1'b0;
      if (q.size() > 0 && cyc == q[0].e0 + q[0].lat) begin
        held     = q[0].r;
        done_exp = 1'b1;
        q.delete(0);
      end
      busy_exp = model_busy();
      chk("done",      64'(bus.done),      64'(done_exp));
      chk("busy",      64'(bus.busy),      64'(busy_exp));
      chk("stall_req", 64'(bus.stall_req), 64'(busy_exp || bus.start));
      chk("result_lo", 64'(bus.result_lo), 64'(held.lo));
      chk("result_hi", 64'(bus.result_hi), 64'(held.hi));
      chk("div0",      64'(bus.div0),      64'(held.div0));
      chk("overflow",  64'(bus.overflow),  64'(held.ovf));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input mdu_op_e op, input logic [15:0] a, input logic [15:0] b,
                       input logic fl, output int lat);
    exp_t e;
    lat = model_lat(op, a, b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.flush = fl;
    if (fl) flush_edge = cyc + 1;
    else if (!model_busy()) begin
      e.e0 = cyc + 1; e.lat = lat; e.r = model(op, a, b);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy),      64'd0);
    chk({tag, "_done"}, 64'(bus.done),      64'd0);
    chk({tag, "_lo"},   64'(bus.result_lo), 64'd0);
    chk({tag, "_hi"},   64'(bus.result_hi), 64'd0);
    chk({tag, "_div0"}, 64'(bus.div0),      64'd0);
    chk({tag, "_ovf"},  64'(bus.overflow),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat2, gap, sel;
    mdu_op_e     op;
    logic [15:0] ra, rb;

    bus.start = 1'b0; bus.op = MUL; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    rst = 1'b1;
    wait_cycles(3);
    chk_zero("reset");
    rst = 1'b0;

    chk("model_mul",    64'(model(MUL,  16'hFFFD, 16'h0007)), 64'(mk(16'hFFEB, 16'hFFFF, 1'b0, 1'b0)));
    chk("model_divu",   64'(model(DIVU, 16'd100,  16'd7)),    64'(mk(16'd14,   16'd2,    1'b0, 1'b0)));
    chk("model_div",    64'(model(DIV,  16'hFFF9, 16'h0002)), 64'(mk(16'hFFFD, 16'hFFFF, 1'b0, 1'b0)));
    chk("model_mulu",   64'(model(MULU, 16'hFFFF, 16'hFFFF)), 64'(mk(16'h0001, 16'hFFFE, 1'b0, 1'b1)));
    chk("model_mulovf", 64'(model(MUL,  16'h0100, 16'h0100)), 64'(mk(16'h0000, 16'h0001, 1'b0, 1'b1)));
    chk("model_div0",   64'(model(DIV,  16'h1234, 16'h0000)), 64'(mk(16'hFFFF, 16'h1234, 1'b1, 1'b0)));
    chk("model_divovf", 64'(model(DIV,  16'h8000, 16'hFFFF)), 64'(mk(16'h8000, 16'h0000, 1'b0, 1'b1)));
    chk("model_lat_run",   64'(model_lat(MUL, 16'h1, 16'h1)), 64'd18);
    chk("model_lat_early", 64'(model_lat(DIVU, 16'h1, 16'h0)), 64'd2);

    // Directed operations
    issue(MUL,  16'hFFFD, 16'h0007, 1'b0, lat); drain();
    issue(DIVU, 16'd100,  16'd7,    1'b0, lat); drain();
    issue(DIV,  16'hFFF9, 16'h0002, 1'b0, lat); drain();
    issue(MULU, 16'hFFFF, 16'hFFFF, 1'b0, lat); drain();
    issue(MUL,  16'h0100, 16'h0100, 1'b0, lat); drain();
    issue(DIV,  16'h1234, 16'h0000, 1'b0, lat); drain();
    issue(DIV,  16'h8000, 16'hFFFF, 1'b0, lat); drain();
    issue(DIVU, 16'h8000, 16'hFFFF, 1'b0, lat); drain();

    // Flush sampled at E0+5 kills the operation
    issue(DIVU, 16'd1000, 16'd3, 1'b0, lat);
    wait_cycles(4);
    bus.flush = 1'b1; flush_edge = cyc + 1;
    wait_cycles(1);
    bus.flush = 1'b0;
    wait_cycles(3);
    chk("flush_drained", 64'(q.size()), 64'd0);

    // Start coinciding with flush is dropped
    issue(MUL, 16'd5, 16'd6, 1'b1, lat);
    wait_cycles(3);

    // Start while busy is ignored
    issue(DIV, 16'hFF00, 16'h0013, 1'b0, lat);
    wait_cycles(5);
    issue(MULU, 16'hABCD, 16'h1234, 1'b0, lat2);
    drain();

    // Back-to-back: second start in the DONE cycle
    issue(MULU, 16'd1234, 16'd5678, 1'b0, lat);
    wait_cycles(lat);
    issue(DIV, 16'hFF9C, 16'd7, 1'b0, lat);
    wait_cycles(lat);
    issue(DIVU, 16'd5, 16'd0, 1'b0, lat);
    wait_cycles(lat);
    issue(MUL, 16'h7FFF, 16'h7FFF, 1'b0, lat);
    drain();

    // Randomised traffic with corner-biased operands
    for (int i = 0; i < 60; i++) begin
      op  = mdu_op_e'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (sel == 0) rb = 16'h0;
      else if (sel == 1) rb = 16'($urandom_range(1, 15));
      else if (sel == 2) begin ra = 16'h8000; rb = 16'hFFFF; end
      else if (sel == 3) ra = 16'h8000;
      issue(op, ra, rb, 1'b0, lat);
      wait_cycles(lat);
      gap = $urandom_range(0, 2);
      wait_cycles(gap);
    end
    drain();

    // Asynchronous reset in the middle of RUN
    issue(MUL, 16'h1357, 16'h2468, 1'b0, lat);
    wait_cycles(6);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    chk("midrst_stall", 64'(bus.stall_req), 64'd0);
    q.delete();
    held = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(3);
    issue(DIVU, 16'd77, 16'd5, 1'b0, lat);
    drain();

    wait_cycles(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
